// File: rtl/graphic_init_sequencer.sv
// graphic_init_sequencer: walks a register-init table and replays it as AHB-Lite single writes.
// Define GRAPHIC_INIT_READBACK_EN to read back and verify every written entry.
module graphic_init_sequencer #(
  parameter int TBL_DEPTH = 16,
  parameter int IW = $clog2(TBL_DEPTH)
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          start,
  input  logic [IW:0]   cfg_count,
  output logic [IW-1:0] tbl_idx,
  input  logic [31:0]   tbl_addr,
  input  logic [31:0]   tbl_data,
  output logic [31:0]   haddr_m,
  output logic [1:0]    htrans_m,
  output logic          hwrite_m,
  output logic [2:0]    hsize_m,
  output logic [2:0]    hburst_m,
  output logic [31:0]   hwdata_m,
  input  logic [31:0]   hrdata_m,
  input  logic          hready_m,
  input  logic          hresp_m,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [IW-1:0] err_idx
);
`ifdef GRAPHIC_INIT_READBACK_EN
  typedef enum logic [2:0] {IDLE, FETCH, ADDR, DATA, RB_ADDR, RB_DATA, DONE, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, ADDR, DATA, DONE, ERROR} state_t;
  logic unused_hrdata;
  assign unused_hrdata = ^hrdata_m;
`endif
  localparam logic [IW:0] DEPTH_V = (IW+1)'(TBL_DEPTH);
  state_t state, nxt, fin;
  logic [IW:0] cnt_q;
  logic [31:0] wdata_q;
  logic start_ok;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);
  assign fin = ({1'b0, tbl_idx} + (IW+1)'(1) == cnt_q) ? DONE : FETCH;
  assign busy = !(state == IDLE || state == DONE || state == ERROR);
  assign done = state == DONE;
  assign err = state == ERROR;
  assign hwrite_m = state == ADDR;
`ifdef GRAPHIC_INIT_READBACK_EN
  assign htrans_m = (state == ADDR || state == RB_ADDR) ? 2'b10 : 2'b00;
`else
  assign htrans_m = (state == ADDR) ? 2'b10 : 2'b00;
`endif
  assign hsize_m = 3'b010;
  assign hburst_m = 3'b000;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: nxt = !start ? state : (cfg_count == '0) ? DONE : FETCH;
      FETCH: nxt = ADDR;
      ADDR: nxt = hready_m ? DATA : ADDR;
`ifdef GRAPHIC_INIT_READBACK_EN
      DATA: nxt = hresp_m ? ERROR : hready_m ? RB_ADDR : DATA;
      RB_ADDR: nxt = hready_m ? RB_DATA : RB_ADDR;
      RB_DATA: nxt = (hresp_m || (hready_m && hrdata_m != wdata_q)) ? ERROR : hready_m ? fin : RB_DATA;
`else
      DATA: nxt = hresp_m ? ERROR : hready_m ? fin : DATA;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
      tbl_idx <= '0;
      cnt_q <= '0;
      wdata_q <= '0;
      haddr_m <= '0;
      hwdata_m <= '0;
      err_idx <= '0;
    end else begin
      state <= nxt;
      if (start_ok) begin
        cnt_q <= (cfg_count > DEPTH_V) ? DEPTH_V : cfg_count;
        tbl_idx <= '0;
        err_idx <= '0;
      end
      if (state == FETCH) begin
        haddr_m <= tbl_addr;
        wdata_q <= tbl_data;
      end
      if (state == ADDR && hready_m) hwdata_m <= wdata_q;
      if (busy && nxt == FETCH) tbl_idx <= tbl_idx + IW'(1);
      if (busy && nxt == ERROR) err_idx <= tbl_idx;
    end
  end
endmodule

// File: tb/tb_graphic_init_sequencer.sv
// tb_graphic_init_sequencer: directed and randomized table runs against a transfer-list model.
module tb_graphic_init_sequencer;
  logic hclk = 0, hresetn = 0, start = 0;
  logic [4:0] cfg_count = 0;
  logic [3:0] tbl_idx, err_idx;
  logic [31:0] tbl_addr, tbl_data, haddr_m, hwdata_m, hrdata_m = 0;
  logic [1:0] htrans_m;
  logic [2:0] hsize_m, hburst_m;
  logic hwrite_m, hready_m = 1, hresp_m = 0, busy, done, err;
  logic [31:0] rom_a [16], rom_d [16];
  int n_cmp = 0, n_bad = 0;
  int ws [16];
  int err_at = -1, bad_rb = -1, unstable = 0;
  logic [31:0] obs_a [$], wd_q [$];
  logic obs_w [$];
  logic dp = 0, pend = 0, last_rdy = 1, cur_wr = 0;
  int wleft = 0;
  logic [3:0] cur_idx = 0;
  logic [31:0] last_wd = 0, dp_haddr = 0, dp_hwdata = 0;
`ifdef GRAPHIC_INIT_READBACK_EN
  localparam bit RB = 1;
`else
  localparam bit RB = 0;
`endif

  graphic_init_sequencer #(.TBL_DEPTH(16)) dut (
    .hclk(hclk), .hresetn(hresetn), .start(start), .cfg_count(cfg_count),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .haddr_m(haddr_m), .htrans_m(htrans_m), .hwrite_m(hwrite_m), .hsize_m(hsize_m),
    .hburst_m(hburst_m), .hwdata_m(hwdata_m), .hrdata_m(hrdata_m), .hready_m(hready_m),
    .hresp_m(hresp_m), .busy(busy), .done(done), .err(err), .err_idx(err_idx));

  always #5 hclk = ~hclk;
  assign tbl_addr = rom_a[tbl_idx];
  assign tbl_data = rom_d[tbl_idx];

  // Slave: accepts every address phase, stretches write data phases by ws[idx], answers reads with the last write.
  always @(negedge hclk) begin
    if (!hresetn) begin
      dp = 0; pend = 0; last_rdy = 1; hready_m = 1; hresp_m = 0;
    end else begin
      if (dp && last_rdy) dp = 0;
      if (pend) begin
        dp = 1; pend = 0;
        wleft = cur_wr ? ws[cur_idx] : 0;
        dp_haddr = haddr_m; dp_hwdata = hwdata_m;
      end
      if (dp && (haddr_m !== dp_haddr || hwdata_m !== dp_hwdata || htrans_m !== 2'b00)) unstable++;
      if (dp && wleft > 0) begin
        hready_m = 0; hresp_m = 0; wleft--;
      end else if (dp) begin
        hready_m = 1;
        hresp_m = cur_wr && int'(cur_idx) == err_at;
        hrdata_m = (!cur_wr && int'(cur_idx) == bad_rb) ? 32'hDEAD : last_wd;
        if (cur_wr) begin wd_q.push_back(hwdata_m); last_wd = hwdata_m; end
      end else begin
        hready_m = 1; hresp_m = 0;
      end
      if (htrans_m == 2'b10) begin
        pend = 1; cur_idx = tbl_idx; cur_wr = hwrite_m;
        obs_a.push_back(haddr_m); obs_w.push_back(hwrite_m);
      end
      last_rdy = hready_m;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_case(input int n, input int e, input int b, input bit poke);
    logic [31:0] ea [$], ed [$];
    logic ew [$];
    int m, cyc, k;
    bit t_err;
    int eidx;
    obs_a.delete(); obs_w.delete(); wd_q.delete(); unstable = 0;
    err_at = e; bad_rb = b;
    m = n > 16 ? 16 : n;
    cyc = 0; t_err = 0; eidx = 0;
    for (int i = 0; i < m; i++) begin
      cyc += 3 + ws[i];
      ea.push_back(rom_a[i]); ew.push_back(1); ed.push_back(rom_d[i]);
      if (i == e) begin t_err = 1; eidx = i; break; end
      if (RB) begin
        cyc += 2;
        ea.push_back(rom_a[i]); ew.push_back(0);
        if (i == b) begin t_err = 1; eidx = i; break; end
      end
    end
    @(negedge hclk);
    cfg_count = 5'(n); start = 1;
    @(posedge hclk); #1;
    start = 0; cfg_count = 5'($urandom);
    k = 0;
    while (!(done || err) && k < 2000) begin
      @(posedge hclk); #1;
      k++;
      start = poke && k == 2;
      if (start) cfg_count = 5'd1;
    end
    start = 0;
    chk("cycles", k, cyc);
    chk("done", done, !t_err);
    chk("err", err, t_err);
    if (t_err) chk("err_idx", err_idx, eidx);
    chk("busy_end", busy, 0);
    chk("htrans_end", htrans_m, 2'b00);
    chk("stable", unstable, 0);
    chk("n_xfer", obs_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < obs_a.size(); i++) begin
      chk($sformatf("addr%0d", i), obs_a[i], ea[i]);
      chk($sformatf("write%0d", i), obs_w[i], ew[i]);
    end
    chk("n_wdata", wd_q.size(), ed.size());
    for (int i = 0; i < ed.size() && i < wd_q.size(); i++) chk($sformatf("wdata%0d", i), wd_q[i], ed[i]);
    repeat (2) @(negedge hclk);
    chk("hold_done", done, !t_err);
  endtask

  initial begin
    int n, e, b, k;
    for (int i = 0; i < 16; i++) begin rom_a[i] = 32'(4 * i); rom_d[i] = 32'(i + 1); ws[i] = 0; end
    repeat (3) @(posedge hclk); #1;
    chk("rst_htrans", htrans_m, 2'b00);
    chk("rst_hwrite", hwrite_m, 0);
    chk("rst_hsize", hsize_m, 3'b010);
    chk("rst_hburst", hburst_m, 3'b000);
    chk("rst_haddr", haddr_m, 0);
    chk("rst_hwdata", hwdata_m, 0);
    chk("rst_flags", {busy, done, err}, 3'b000);
    chk("rst_idx", {tbl_idx, err_idx}, 8'h00);
    @(negedge hclk); hresetn = 1;
    repeat (2) @(negedge hclk);
    chk("idle_busy", busy, 0);
    run_case(3, -1, -1, 0);
    ws[1] = 2;
    run_case(3, -1, -1, 0);
    ws[1] = 0;
    run_case(4, 2, -1, 0);
    run_case(0, -1, -1, 0);
    run_case(5, -1, -1, 1);
    run_case(20, -1, -1, 0);
    if (RB) begin
      rom_d[0] = 32'h1;
      run_case(3, -1, 0, 0);
      run_case(3, -1, -1, 0);
    end
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        rom_a[i] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        rom_d[i] = $urandom;
        ws[i] = $urandom_range(0, 2);
      end
      n = $urandom_range(1, 19);
      e = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (n > 16 ? 16 : n) - 1) : -1;
      b = (RB && $urandom_range(0, 2) == 0) ? $urandom_range(0, (n > 16 ? 16 : n) - 1) : -1;
      run_case(n, e, b, $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 16; i++) ws[i] = 0;
    err_at = -1; bad_rb = -1;
    obs_a.delete(); obs_w.delete();
    @(negedge hclk); cfg_count = 5'd4; start = 1;
    @(negedge hclk); start = 0;
    k = 0;
    while (obs_a.size() < (RB ? 3 : 2) && k < 100) begin @(negedge hclk); #1; k++; end
    chk("reach_entry1", k < 100, 1);
    @(negedge hclk);
    hresetn = 0; #1;
    chk("mid_htrans", htrans_m, 2'b00);
    chk("mid_hwrite", hwrite_m, 0);
    chk("mid_haddr", haddr_m, 0);
    chk("mid_hwdata", hwdata_m, 0);
    chk("mid_flags", {busy, done, err}, 3'b000);
    chk("mid_idx", {tbl_idx, err_idx}, 8'h00);
    repeat (2) @(negedge hclk);
    hresetn = 1;
    k = obs_a.size();
    repeat (20) @(negedge hclk);
    chk("no_resume", obs_a.size(), k);
    chk("post_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/graphic_init_sequencer.md
GRAPHIC_INIT_SEQUENCER -- requirements
Module: graphic_init_sequencer

Interface
REQ-001 SHALL have parameter TBL_DEPTH, default 16, number of table entries (power of two, 2..256).
REQ-002 SHALL have parameter IW, default $clog2(TBL_DEPTH), table index width.
REQ-003 SHALL have port hclk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port hresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse, begins a table run.
REQ-006 SHALL have port cfg_count  input  IW+1  number of entries to write, sampled on accepted start.
REQ-007 SHALL have port tbl_idx  output  IW  index into external synchronous table ROM.
REQ-008 SHALL have ports tbl_addr  input  32  and  tbl_data  input  32  ROM contents, valid one cycle after tbl_idx changes.
REQ-009 SHALL have ports haddr_m 32, htrans_m 2, hwrite_m 1, hsize_m 3, hburst_m 3, hwdata_m 32 (outputs) and hrdata_m 32, hready_m 1, hresp_m 1 (inputs), forming an AHB-Lite master to the graphic subsystem slave port.
REQ-010 SHALL have outputs busy 1, done 1, err 1, err_idx IW (index of failing entry).

Function
REQ-011 SHALL implement states IDLE, FETCH, ADDR, DATA, RB_ADDR, RB_DATA, DONE, ERROR.
REQ-012 IDLE: start=1 latches cfg_count, clears done/err, sets tbl_idx=0; cfg_count=0 -> DONE, else -> FETCH.
REQ-013 start while busy=1 SHALL be ignored; start in DONE or ERROR SHALL behave as in IDLE.
REQ-014 FETCH SHALL last exactly one cycle, registering tbl_addr/tbl_data, then -> ADDR.
REQ-015 ADDR SHALL drive htrans_m=2'b10 (NONSEQ), hwrite_m=1, hsize_m=3'b010, hburst_m=3'b000, haddr_m=latched address; -> DATA on first cycle with hready_m=1, holding all signals stable until then.
REQ-016 DATA SHALL drive htrans_m=2'b00 and hwdata_m=latched data; on hready_m=1 and hresp_m=0, finish entry per REQ-018 (or RB_ADDR when readback enabled).
REQ-017 hresp_m=1 in any data phase SHALL -> ERROR with err=1, err_idx=current index; remaining entries not issued.
REQ-018 Entry finish: if index+1 == latched count -> DONE, else increment tbl_idx -> FETCH; minimum 3 cycles per entry with zero wait states.
REQ-019 DONE/ERROR SHALL hold done=1 (DONE) or err=1 (ERROR) until next start or reset; busy=1 only in FETCH..RB_DATA.
REQ-020 Outside ADDR/RB_ADDR htrans_m SHALL be 2'b00; haddr_m/hwdata_m hold last value.
REQ-021 cfg_count > TBL_DEPTH SHALL be saturated to TBL_DEPTH when latched.

Reset
REQ-022 hresetn=0 SHALL asynchronously force IDLE, tbl_idx=0, htrans_m=2'b00, hwrite_m=0, hsize_m=3'b010, hburst_m=3'b000, haddr_m=0, hwdata_m=0, busy=0, done=0, err=0, err_idx=0.
REQ-023 Reset mid-transfer SHALL abandon the run; no transfer resumes after release without a new start.

Configuration
REQ-024 Macro GRAPHIC_INIT_READBACK_EN defined: after each successful write, RB_ADDR issues NONSEQ read (hwrite_m=0) to same address; RB_DATA on hready_m=1 compares hrdata_m with written data; mismatch or hresp_m=1 -> ERROR with err_idx; match -> finish per REQ-018.
REQ-025 Macro undefined: RB_ADDR/RB_DATA states and comparator SHALL not exist; hwrite_m=1 in every NONSEQ.

Verification
REQ-026 cfg_count=3, table {0x00:0x1, 0x04:0x2, 0x08:0x3}, zero-wait slave -> three NONSEQ writes in order, done=1 nine cycles after start (no readback), err=0.
REQ-027 Slave inserts 2 wait states on entry 1 -> haddr_m/htrans_m/hwdata_m stable during waits, completion delayed exactly 2 cycles.
REQ-028 hresp_m=1 on entry 2 of 4 -> err=1, err_idx=2, done=0, no NONSEQ for entry 3.
REQ-029 start with cfg_count=0 -> done=1 next cycle, htrans_m never NONSEQ; start pulse while busy -> ignored.
REQ-030 hresetn pulsed low during DATA of entry 1 -> all outputs at reset values immediately, no further transfers.
REQ-031 With GRAPHIC_INIT_READBACK_EN, hrdata_m=0xDEAD on entry 0 readback (written 0x1) -> err=1, err_idx=0; correct readback -> write/read pairs alternate, done=1.
